// File: rtl/multicycle_alu_pkg.sv
// Shared types for the multicycle ALU: funct codes, FSM states
// and the shift-op classifier used by the top-level datapath.
package multicycle_alu_pkg;

    localparam int unsigned NUM_FUNCT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [3:0] {
        F_ADD  = 4'd0,
        F_SUB  = 4'd1,
        F_AND  = 4'd2,
        F_OR   = 4'd3,
        F_XOR  = 4'd4,
        F_SLT  = 4'd5,
        F_SLTU = 4'd6,
        F_SLL  = 4'd7,
        F_SRL  = 4'd8,
        F_SRA  = 4'd9,
        F_EQ   = 4'd10,
        F_NE   = 4'd11,
        F_LT   = 4'd12,
        F_GE   = 4'd13,
        F_LTU  = 4'd14,
        F_GEU  = 4'd15
    } funct_e;

    function automatic logic is_shift_op(funct_e f);
        return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
    endfunction

endpackage

// File: rtl/multicycle_alu_magcmp.sv
// Magnitude comparator: equality plus signed and unsigned less-than.
// Ports: a_i, b_i operands; eq_o, lt_s_o, lt_u_o comparison flags.
module multicycle_alu_magcmp #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  eq_o,
    output logic                  lt_s_o,
    output logic                  lt_u_o
);

    assign eq_o   = (a_i == b_i);
    assign lt_u_o = (a_i < b_i);
    assign lt_s_o = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked execute-stage ALU; single-cycle ops, iterative shifts.
// Ports: in_valid/in_ready/funct/alu_din1/alu_din2 request side;
//        out_valid/out_ready/alu_dout/alu_comp/out_illegal result side.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FUNCT_WIDTH = 5,
    parameter int unsigned SHIFT_STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FUNCT_WIDTH-1:0] funct,
    input  logic [DATA_WIDTH-1:0]  alu_din1,
    input  logic [DATA_WIDTH-1:0]  alu_din2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  alu_dout,
    output logic                   alu_comp,
    output logic                   out_illegal
);

    localparam int unsigned SW = $clog2(DATA_WIDTH);
    // One extra bit so a step equal to DATA_WIDTH still fits.
    localparam logic [SW:0] STEP_L = SHIFT_STEP[SW:0];

    typedef logic [DATA_WIDTH-1:0] word_t;

    state_e      state_q, state_d;
    word_t       res_q, res_d;
    logic        comp_q, comp_d;
    logic        ill_q, ill_d;
    logic [SW:0] rem_q, rem_d;
    funct_e      op_q, op_d;

    logic        legal;
    funct_e      op_f;
    logic [SW:0] shamt;
    logic        eq, lt_s, lt_u;
    word_t       alu_res;
    logic        alu_cmp;

    state_e      l_state;
    word_t       l_res;
    logic        l_comp, l_ill;
    logic [SW:0] l_rem;

    logic [SW:0] step;
    word_t       shifted;

    assign legal = ((funct >> 4) == '0);
    assign op_f  = funct_e'(funct[3:0]);
    assign shamt = {1'b0, alu_din2[SW-1:0]};

    multicycle_alu_magcmp #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .a_i    (alu_din1),
        .b_i    (alu_din2),
        .eq_o   (eq),
        .lt_s_o (lt_s),
        .lt_u_o (lt_u)
    );

    // Shift ops land here only with shamt == 0, so they pass din1 through.
    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        unique case (op_f)
            F_ADD:  alu_res = alu_din1 + alu_din2;
            F_SUB:  alu_res = alu_din1 - alu_din2;
            F_AND:  alu_res = alu_din1 & alu_din2;
            F_OR:   alu_res = alu_din1 | alu_din2;
            F_XOR:  alu_res = alu_din1 ^ alu_din2;
            F_SLT:  alu_res = word_t'(lt_s);
            F_SLTU: alu_res = word_t'(lt_u);
            F_SLL,
            F_SRL,
            F_SRA:  alu_res = alu_din1;
            F_EQ:   alu_cmp = eq;
            F_NE:   alu_cmp = ~eq;
            F_LT:   alu_cmp = lt_s;
            F_GE:   alu_cmp = ~lt_s;
            F_LTU:  alu_cmp = lt_u;
            F_GEU:  alu_cmp = ~lt_u;
        endcase
    end

    // What the unit loads when it accepts a new op.
    always_comb begin
        l_state = ST_DONE;
        l_res   = alu_res;
        l_comp  = alu_cmp;
        l_ill   = 1'b0;
        l_rem   = '0;
        if (!legal) begin
            l_res  = '0;
            l_comp = 1'b0;
            l_ill  = 1'b1;
        end else if (is_shift_op(op_f) && (shamt != '0)) begin
            l_state = ST_SHIFT;
            l_res   = alu_din1;
            l_comp  = 1'b0;
            l_rem   = shamt;
        end
    end

    assign step = (rem_q < STEP_L) ? rem_q : STEP_L;

    always_comb begin
        shifted = res_q;
        unique case (op_q)
            F_SLL:   shifted = res_q << step;
            F_SRL:   shifted = res_q >> step;
            F_SRA:   shifted = word_t'($signed(res_q) >>> step);
            default: shifted = res_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        comp_d  = comp_q;
        ill_d   = ill_q;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = l_state;
                    res_d   = l_res;
                    comp_d  = l_comp;
                    ill_d   = l_ill;
                    rem_d   = l_rem;
                    op_d    = op_f;
                end
            end
            ST_SHIFT: begin
                res_d = shifted;
                rem_d = rem_q - step;
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = l_state;
                        res_d   = l_res;
                        comp_d  = l_comp;
                        ill_d   = l_ill;
                        rem_d   = l_rem;
                        op_d    = op_f;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            comp_q  <= 1'b0;
            ill_q   <= 1'b0;
            rem_q   <= '0;
            op_q    <= F_ADD;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            comp_q  <= comp_d;
            ill_q   <= ill_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE) ||
                         ((state_q == ST_DONE) && out_ready);
    assign out_valid   = (state_q == ST_DONE);
    assign alu_dout    = res_q;
    assign alu_comp    = comp_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised and directed bench for multicycle_alu, two DUTs
// (shift step 1 and shift step 8) sharing one request stream.
module tb_multicycle_alu;

    typedef logic [31:0] word_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  funct;
    word_t       din1, din2;
    logic        rdy  [2];
    logic        ov   [2];
    word_t       dout [2];
    logic        comp [2];
    logic        ill  [2];

    int pass_cnt;
    int total;

    multicycle_alu #(
        .DATA_WIDTH(32), .FUNCT_WIDTH(5), .SHIFT_STEP(1)
    ) u_s1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[0]),
        .funct(funct), .alu_din1(din1), .alu_din2(din2),
        .out_valid(ov[0]), .out_ready(out_ready),
        .alu_dout(dout[0]), .alu_comp(comp[0]),
        .out_illegal(ill[0])
    );

    multicycle_alu #(
        .DATA_WIDTH(32), .FUNCT_WIDTH(5), .SHIFT_STEP(8)
    ) u_s8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy[1]),
        .funct(funct), .alu_din1(din1), .alu_din2(din2),
        .out_valid(ov[1]), .out_ready(out_ready),
        .alu_dout(dout[1]), .alu_comp(comp[1]),
        .out_illegal(ill[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result straight from the op definitions.
    function automatic void model(
        input  int    f,
        input  word_t a,
        input  word_t b,
        input  int    stp,
        output word_t d,
        output logic  c,
        output logic  il,
        output int    lat
    );
        int sh;
        sh  = int'(b % 32);
        d   = 0;
        c   = 0;
        il  = 0;
        lat = 1;
        case (f)
            0:  d = a + b;
            1:  d = a - b;
            2:  d = a & b;
            3:  d = a | b;
            4:  d = a ^ b;
            5:  d = ($signed(a) < $signed(b)) ? 1 : 0;
            6:  d = (a < b) ? 1 : 0;
            7:  d = a << sh;
            8:  d = a >> sh;
            9:  d = $signed(a) >>> sh;
            10: c = (a == b);
            11: c = (a != b);
            12: c = ($signed(a) < $signed(b));
            13: c = ($signed(a) >= $signed(b));
            14: c = (a < b);
            15: c = (a >= b);
            default: il = 1;
        endcase
        if (f >= 7 && f <= 9)
            lat = 1 + (sh + stp - 1) / stp;
    endfunction

    // Issue one op, wait for its result; leaves out_ready untouched.
    task automatic do_op(
        input  int    d,
        input  int    f,
        input  word_t a,
        input  word_t b,
        output word_t rd,
        output logic  rc,
        output logic  ri,
        output int    lat,
        output int    lowr
    );
        int n;
        @(negedge clk);
        funct    = 5'(f);
        din1     = a;
        din2     = b;
        in_valid = 1'b1;
        n = 0;
        while (!rdy[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL accept_timeout got=%0d want<200", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        lowr = 0;
        while (!ov[d] && lat < 200) begin
            if (!rdy[d]) lowr++;
            @(negedge clk);
            lat++;
        end
        rd = dout[d];
        rc = comp[d];
        ri = ill[d];
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        funct     = '0;
        din1      = '0;
        din2      = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({ov[0], comp[0], ill[0]} !== 3'b000 || dout[0] !== 0) begin
            $display("FAIL reset_outs got=%b%b%b/%h want=000/0",
                     ov[0], comp[0], ill[0], dout[0]);
        end else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) begin
            $display("FAIL reset_ready got=%b%b want=11", rdy[0], rdy[1]);
        end else pass_cnt++;
    endtask

    task automatic test_add_wrap();
        word_t d; logic c, i; int l, lr;
        do_op(0, 0, 32'hFFFF_FFFF, 32'h1, d, c, i, l, lr);
        total++;
        if (d !== 0 || c !== 0 || l !== 1) begin
            $display("FAIL add_wrap got=%h/%b/%0d want=0/0/1", d, c, l);
        end else pass_cnt++;
    endtask

    task automatic test_sra();
        word_t d; logic c, i; int l, lr;
        do_op(0, 9, 32'h8000_0000, 32'd4, d, c, i, l, lr);
        total++;
        if (d !== 32'hF800_0000 || l !== 5) begin
            $display("FAIL sra4 got=%h/%0d want=f8000000/5", d, l);
        end else pass_cnt++;
        total++;
        if (lr !== 4) begin
            $display("FAIL sra4_ready_low got=%0d want=4", lr);
        end else pass_cnt++;
    endtask

    task automatic test_compare();
        word_t d; logic c, i; int l, lr;
        do_op(0, 12, 32'hFFFF_FFFF, 32'h1, d, c, i, l, lr);
        total++;
        if (c !== 1 || d !== 0) begin
            $display("FAIL lt_signed got=%b/%h want=1/0", c, d);
        end else pass_cnt++;
        do_op(0, 14, 32'hFFFF_FFFF, 32'h1, d, c, i, l, lr);
        total++;
        if (c !== 0) begin
            $display("FAIL ltu got=%b want=0", c);
        end else pass_cnt++;
        do_op(0, 15, 32'd5, 32'd5, d, c, i, l, lr);
        total++;
        if (c !== 1) begin
            $display("FAIL geu_eq got=%b want=1", c);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        word_t a[4], b[4], e[4];
        int    f[4];
        logic  ec, ei;
        int    el;
        f = '{0, 4, 6, 0};
        for (int k = 0; k < 4; k++) begin
            a[k] = $urandom;
            b[k] = $urandom;
            model(f[k], a[k], b[k], 1, e[k], ec, ei, el);
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            funct = 5'(f[k]); din1 = a[k]; din2 = b[k];
            in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (ov[0] !== 1 || dout[0] !== e[k]) begin
                $display("FAIL b2b_%0d got=%b/%h want=1/%h",
                         k, ov[0], dout[0], e[k]);
            end else pass_cnt++;
        end
        out_ready = 1'b0;
        funct = 5'(f[3]); din1 = a[3]; din2 = b[3];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (ov[0] !== 1 || rdy[0] !== 0 || dout[0] !== e[2]) begin
                $display("FAIL hold_%0d got=%b%b/%h want=10/%h",
                         k, ov[0], rdy[0], dout[0], e[2]);
            end else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (ov[0] !== 1 || dout[0] !== e[3]) begin
            $display("FAIL after_hold got=%b/%h want=1/%h",
                     ov[0], dout[0], e[3]);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_shift_step8();
        word_t d; logic c, i; int l, lr;
        do_op(1, 7, 32'h3, 32'd31, d, c, i, l, lr);
        total++;
        if (d !== 32'h8000_0000 || l !== 5) begin
            $display("FAIL sll31_s8 got=%h/%0d want=80000000/5", d, l);
        end else pass_cnt++;
        @(negedge clk);
        funct = 5'd7; din1 = 32'h3; din2 = 32'd31;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ov[1] !== 0) begin
            $display("FAIL mid_shift_valid got=%b want=0", ov[1]);
        end else pass_cnt++;
        rst = 1'b0;
        #1;
        total++;
        if (ov[1] !== 0 || dout[1] !== 0 || rdy[1] !== 1) begin
            $display("FAIL rst_mid_shift got=%b/%h/%b want=0/0/1",
                     ov[1], dout[1], rdy[1]);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        do_op(1, 0, 32'd10, 32'd20, d, c, i, l, lr);
        total++;
        if (d !== 32'd30 || l !== 1) begin
            $display("FAIL post_rst_add got=%h/%0d want=1e/1", d, l);
        end else pass_cnt++;
    endtask

    task automatic test_illegal();
        word_t d; logic c, i; int l, lr;
        do_op(0, 20, 32'h1234, 32'h5678, d, c, i, l, lr);
        total++;
        if (i !== 1 || d !== 0 || c !== 0 || l !== 1) begin
            $display("FAIL illegal got=%b/%h/%b/%0d want=1/0/0/1",
                     i, d, c, l);
        end else pass_cnt++;
        do_op(0, 0, 32'h1234, 32'h5678, d, c, i, l, lr);
        total++;
        if (i !== 0 || d !== 32'h68AC) begin
            $display("FAIL illegal_clear got=%b/%h want=0/68ac", i, d);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        word_t a, b, d, ed;
        logic  c, i, ec, ei;
        int    f, l, lr, el, sel;
        for (int k = 0; k < 40; k++) begin
            f   = $urandom_range(0, 18);
            sel = $urandom_range(0, 1);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 | a;
            model(f, a, b, (sel == 0) ? 1 : 8, ed, ec, ei, el);
            do_op(sel, f, a, b, d, c, i, l, lr);
            total++;
            if (d !== ed || c !== ec || i !== ei || l !== el) begin
                $display("FAIL rand_%0d f=%0d got=%h/%b/%b/%0d want=%h/%b/%b/%0d",
                         k, f, d, c, i, l, ed, ec, ei, el);
            end else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        total    = 0;
        test_reset();
        test_add_wrap();
        test_sra();
        test_compare();
        test_back_to_back();
        test_shift_step8();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
